dmem_responder: RTL and testbench

Shared data-memory responder serving the data-side read/write requests of `NUM_CORES` matrix-multiplication cores. It holds the data RAM and arbitrates one access per clock using a round-robin scheme. It returns read data to each core with a one-cycle acknowledge. A host port with absolute priority preloads operand matrices and reads back results. The block also aggregates the cores' completion flags into a single done signal.

---
 rtl/dmem_responder_if.sv | 33 +++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the matrix cores, the host and the shared data memory.
// Ports: per-core req_addr/req_wdata/req_read/req_write in, rsp_rdata/rsp_ack out;
//        host_en/host_we/host_addr/host_wdata in, host_rdata out (directions as seen by the responder).
interface dmem_responder_if #(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 16
);
   logic [NUM_CORES*16-1:0]     req_addr;
   logic [NUM_CORES*DATA_W-1:0] req_wdata;
   logic [NUM_CORES-1:0]        req_read;
   logic [NUM_CORES-1:0]        req_write;
   logic [NUM_CORES*DATA_W-1:0] rsp_rdata;
   logic [NUM_CORES-1:0]        rsp_ack;
   logic                        host_en;
   logic                        host_we;
   logic [15:0]                 host_addr;
   logic [DATA_W-1:0]           host_wdata;
   logic [DATA_W-1:0]           host_rdata;

   // Requester side: cores and host drive requests, observe responses.
   modport master (
      output req_addr, req_wdata, req_read, req_write,
      output host_en, host_we, host_addr, host_wdata,
      input  rsp_rdata, rsp_ack, host_rdata
   );

   // Responder side: the shared data memory.
   modport slave (
      input  req_addr, req_wdata, req_read, req_write,
      input  host_en, host_we, host_addr, host_wdata,
      output rsp_rdata, rsp_ack, host_rdata
   );
endinterface

// File: rtl/dmem_responder.sv
// Shared data RAM for NUM_CORES cores: round-robin one access per clock, host has absolute priority.
// Ports: clk, RESET_N (async active-low), bus (slave side of dmem_responder_if),
//        end_in (per-core completion) -> all_done (registered AND), addr_err (sticky out-of-range flag).
module dmem_responder #(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 12,
   parameter int DEPTH     = 4096
) (
   input  logic                 clk,
   input  logic                 RESET_N,
   dmem_responder_if.slave      bus,
   input  logic [NUM_CORES-1:0] end_in,
   output logic                 all_done,
   output logic                 addr_err
);
   localparam int          PW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   logic [NUM_CORES-1:0][15:0]       core_addr;
   logic [NUM_CORES-1:0][DATA_W-1:0] core_wdata;
   logic [NUM_CORES-1:0]             elig;
   logic [PW-1:0]                    ptr;
   logic [PW-1:0]                    grant_idx;
   logic                             grant_vld;
   logic [NUM_CORES-1:0]             ack_q;
   logic [NUM_CORES-1:0][DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0]                host_rdata_q;
   logic                             all_done_q;
   logic                             addr_err_q;

   logic                             acc_en;
   logic                             acc_we;
   logic                             acc_ok;
   logic [15:0]                      acc_addr;
   logic [DATA_W-1:0]                acc_wdata;
   logic [ADDR_W-1:0]                acc_idx;
   logic [DATA_W-1:0]                rd_word;

   logic [DATA_W-1:0]                mem [DEPTH];

   // Index of the i-th core scanned from base, wrapping at NUM_CORES-1.
   function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_CORES) s = s - NUM_CORES;
      return PW'(s);
   endfunction

   function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
      return (g == PW'(NUM_CORES - 1)) ? '0 : g + 1'b1;
   endfunction

   assign core_addr  = bus.req_addr;
   assign core_wdata = bus.req_wdata;

   // A core whose ack is high this cycle has not had a chance to drop its
   // level request yet, so it is masked to avoid servicing it twice.
   assign elig = (bus.req_read | bus.req_write) & ~ack_q & {NUM_CORES{~bus.host_en}};

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!grant_vld && elig[rr_idx(ptr, i)]) begin
            grant_vld = 1'b1;
            grant_idx = rr_idx(ptr, i);
         end
      end
   end

   // Single RAM port: host wins; a core grant never coexists with host_en.
   // When a core raises read and write together, the write is performed.
   always_comb begin
      acc_en    = 1'b0;
      acc_we    = 1'b0;
      acc_addr  = '0;
      acc_wdata = '0;
      if (bus.host_en) begin
         acc_en    = 1'b1;
         acc_we    = bus.host_we;
         acc_addr  = bus.host_addr;
         acc_wdata = bus.host_wdata;
      end else if (grant_vld) begin
         acc_en    = 1'b1;
         acc_we    = bus.req_write[grant_idx];
         acc_addr  = core_addr[grant_idx];
         acc_wdata = core_wdata[grant_idx];
      end
   end

   assign acc_ok  = ({1'b0, acc_addr} < DEPTH_L);
   assign acc_idx = acc_addr[ADDR_W-1:0];
   assign rd_word = acc_ok ? mem[acc_idx] : '0;

   // RAM contents survive reset, so the array lives in its own unreset block.
   always_ff @(posedge clk) begin
      if (acc_en && acc_we && acc_ok) mem[acc_idx] <= acc_wdata;
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         ptr          <= '0;
         ack_q        <= '0;
         rdata_q      <= '0;
         host_rdata_q <= '0;
         all_done_q   <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         ack_q      <= '0;
         all_done_q <= &end_in;
         if (grant_vld) begin
            ptr              <= ptr_after(grant_idx);
            ack_q[grant_idx] <= 1'b1;
            if (!acc_we) rdata_q[grant_idx] <= rd_word;
         end
         if (bus.host_en && !bus.host_we) host_rdata_q <= rd_word;
         if (acc_en && !acc_ok) addr_err_q <= 1'b1;
      end
   end

   assign bus.rsp_ack    = ack_q;
   assign bus.rsp_rdata  = rdata_q;
   assign bus.host_rdata = host_rdata_q;
   assign all_done       = all_done_q;
   assign addr_err       = addr_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: per-cycle vector table plus hand-written reset sequences.
// Ports: none; drives the interface, end_in and reset, checks acks, read data and flags.
module tb_dmem_responder;
   logic       clk;
   logic       rst_n;
   logic [3:0] end_in;
   logic       all_done;
   logic       addr_err;

   int checks   = 0;
   int failures = 0;

   dmem_responder_if #(.NUM_CORES(4), .DATA_W(16)) bus ();

   dmem_responder #(
      .NUM_CORES(4), .DATA_W(16), .ADDR_W(12), .DEPTH(4096)
   ) dut (
      .clk     (clk),
      .RESET_N (rst_n),
      .bus     (bus.slave),
      .end_in  (end_in),
      .all_done(all_done),
      .addr_err(addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic             h_en;
      logic             h_we;
      logic [15:0]      h_addr;
      logic [15:0]      h_wdata;
      logic [3:0]       rd;
      logic [3:0]       wr;
      logic [3:0][15:0] addr;
      logic [3:0][15:0] wdata;
      logic [3:0]       endv;
      logic [3:0]       e_ack;
      logic [3:0][15:0] e_rdata;
      logic [15:0]      e_hr;
      logic             e_done;
      logic             e_err;
   } vec_t;

   vec_t             vt[$];
   vec_t             v;
   logic [3:0][15:0] er;

   task automatic clr();
      v = '{default: '0};
   endtask

   task automatic hst(input logic we, input logic [15:0] a, input logic [15:0] d);
      v.h_en = 1'b1; v.h_we = we; v.h_addr = a; v.h_wdata = d;
   endtask

   task automatic crd(input int k, input logic [15:0] a);
      v.rd[k] = 1'b1; v.addr[k] = a;
   endtask

   task automatic cwr(input int k, input logic [15:0] a, input logic [15:0] d);
      v.wr[k] = 1'b1; v.addr[k] = a; v.wdata[k] = d;
   endtask

   task automatic push(input logic [3:0] ack, input logic [15:0] hr, input logic done, input logic err);
      v.e_ack = ack; v.e_rdata = er; v.e_hr = hr; v.e_done = done; v.e_err = err;
      vt.push_back(v);
      clr();
   endtask

   task automatic drive(input vec_t x);
      bus.host_en    = x.h_en;
      bus.host_we    = x.h_we;
      bus.host_addr  = x.h_addr;
      bus.host_wdata = x.h_wdata;
      bus.req_read   = x.rd;
      bus.req_write  = x.wr;
      bus.req_addr   = x.addr;
      bus.req_wdata  = x.wdata;
      end_in         = x.endv;
   endtask

   task automatic idle();
      clr();
      drive(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] ack, input logic [63:0] rdata,
                          input logic [15:0] hr, input logic done, input logic err);
      chk({tag, " ack"},        64'(bus.rsp_ack),    64'(ack));
      chk({tag, " rdata"},      bus.rsp_rdata,       rdata);
      chk({tag, " host_rdata"}, 64'(bus.host_rdata), 64'(hr));
      chk({tag, " all_done"},   64'(all_done),       64'(done));
      chk({tag, " addr_err"},   64'(addr_err),       64'(err));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] rd_keep;

      rst_n = 1'b0;
      idle();
      er = '0;

      // ---- vector table: one entry per clock, expectations after that edge ----
      hst(1, 16'h0010, 16'hBEEF);                          push(4'b0000, 16'h0000, 0, 0); // V0
      hst(1, 16'h0011, 16'h1111); v.endv = 4'b1111;        push(4'b0000, 16'h0000, 1, 0); // V1
      hst(1, 16'h0012, 16'h2222); v.endv = 4'b1011;        push(4'b0000, 16'h0000, 0, 0); // V2
      hst(1, 16'h0013, 16'h3333); v.endv = 4'b1111;        push(4'b0000, 16'h0000, 1, 0); // V3
      hst(0, 16'h0012, 16'h0000);                          push(4'b0000, 16'h2222, 0, 0); // V4
      // all four cores read at once, ptr=0
      crd(0, 16'h0010); crd(1, 16'h0011); crd(2, 16'h0012); crd(3, 16'h0013);
      er[0] = 16'hBEEF;                                    push(4'b0001, 16'h2222, 0, 0); // V5
      crd(1, 16'h0011); crd(2, 16'h0012); crd(3, 16'h0013);
      er[1] = 16'h1111;                                    push(4'b0010, 16'h2222, 0, 0); // V6
      crd(2, 16'h0012); crd(3, 16'h0013);
      er[2] = 16'h2222;                                    push(4'b0100, 16'h2222, 0, 0); // V7
      crd(3, 16'h0013);
      er[3] = 16'h3333;                                    push(4'b1000, 16'h2222, 0, 0); // V8
      crd(3, 16'h0013);                                    push(4'b0000, 16'h2222, 0, 0); // V9 masked
      // core 0 continuous, core 2 once
      crd(0, 16'h0011); crd(2, 16'h0013);
      er[0] = 16'h1111;                                    push(4'b0001, 16'h2222, 0, 0); // V10
      crd(0, 16'h0011); crd(2, 16'h0013);
      er[2] = 16'h3333;                                    push(4'b0100, 16'h2222, 0, 0); // V11
      crd(0, 16'h0011);                                    push(4'b0001, 16'h2222, 0, 0); // V12
      crd(0, 16'h0011);                                    push(4'b0000, 16'h2222, 0, 0); // V13
      crd(0, 16'h0011);                                    push(4'b0001, 16'h2222, 0, 0); // V14
                                                           push(4'b0000, 16'h2222, 0, 0); // V15
      // single read by core 1: one-cycle ack, data held
      crd(1, 16'h0010);
      er[1] = 16'hBEEF;                                    push(4'b0010, 16'h2222, 0, 0); // V16
                                                           push(4'b0000, 16'h2222, 0, 0); // V17
      // host busy three cycles while cores 0 and 3 wait (ptr=2)
      hst(0, 16'h0013, 16'h0000); crd(0, 16'h0012); crd(3, 16'h0010);
                                                           push(4'b0000, 16'h3333, 0, 0); // V18
      hst(1, 16'h0388, 16'h5A5A); crd(0, 16'h0012); crd(3, 16'h0010);
                                                           push(4'b0000, 16'h3333, 0, 0); // V19
      hst(0, 16'h0010, 16'h0000); crd(0, 16'h0012); crd(3, 16'h0010);
                                                           push(4'b0000, 16'hBEEF, 0, 0); // V20
      crd(0, 16'h0012); crd(3, 16'h0010);
      er[3] = 16'hBEEF;                                    push(4'b1000, 16'hBEEF, 0, 0); // V21
      crd(0, 16'h0012);
      er[0] = 16'h2222;                                    push(4'b0001, 16'hBEEF, 0, 0); // V22
                                                           push(4'b0000, 16'hBEEF, 0, 0); // V23
      // out-of-range write 5000 (aliases 0x388 in 12 bits) must be dropped
      cwr(2, 16'd5000, 16'h1234);                          push(4'b0100, 16'hBEEF, 0, 1); // V24
                                                           push(4'b0000, 16'hBEEF, 0, 1); // V25
      crd(2, 16'd5000);
      er[2] = 16'h0000;                                    push(4'b0100, 16'hBEEF, 0, 1); // V26
      hst(0, 16'h0388, 16'h0000);                          push(4'b0000, 16'h5A5A, 0, 1); // V27
      hst(0, 16'h2000, 16'h0000);                          push(4'b0000, 16'h0000, 0, 1); // V28

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 4'b0000, 64'h0, 16'h0000, 1'b0, 1'b0);
      #2 rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i]);
         step();
         chk_all($sformatf("vec%0d", i), vt[i].e_ack, 64'(vt[i].e_rdata), vt[i].e_hr,
                 vt[i].e_done, vt[i].e_err);
      end

      // ---- core 1 read+write together at 0x20 (ptr=3 here) ----
      rd_keep = bus.rsp_rdata;
      idle();
      bus.req_read[1]        = 1'b1;
      bus.req_write[1]       = 1'b1;
      bus.req_addr[31:16]    = 16'h0020;
      bus.req_wdata[31:16]   = 16'h00AA;
      step();
      chk("rw ack",   64'(bus.rsp_ack), 64'(4'b0010));
      chk("rw rdata", bus.rsp_rdata,    rd_keep);
      idle();
      step();
      chk("rw single ack", 64'(bus.rsp_ack), 64'(4'b0000));
      bus.host_en   = 1'b1;
      bus.host_we   = 1'b0;
      bus.host_addr = 16'h0020;
      step();
      chk("rw ram", 64'(bus.host_rdata), 64'(16'h00AA));

      // ---- reset mid-burst: core 2 granted (ptr -> 3), then reset with 1 and 3 pending ----
      idle();
      bus.req_read[2]      = 1'b1;
      bus.req_addr[47:32]  = 16'h0010;
      step();
      chk("pre-rst ack", 64'(bus.rsp_ack), 64'(4'b0100));
      bus.req_read         = 4'b1010;
      bus.req_addr[31:16]  = 16'h0010;
      bus.req_addr[63:48]  = 16'h0010;
      #2 rst_n = 1'b0;
      #1;
      chk_all("mid-rst", 4'b0000, 64'h0, 16'h0000, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      chk("post-rst ack", 64'(bus.rsp_ack), 64'(4'b0010));
      chk("post-rst rdata1", 64'(bus.rsp_rdata[31:16]), 64'(16'hBEEF));
      bus.req_read = 4'b1000;
      step();
      chk("post-rst ack2", 64'(bus.rsp_ack), 64'(4'b1000));
      idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
